// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcodes, instruction formats and opcode-to-format mapping
package riscv_pkg;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILLEGAL} instr_fmt_t;

    function automatic instr_fmt_t opcode_to_fmt(input logic [6:0] opcode);
        case (opcode)
            OPCODE_OP:                               return FMT_R;
            OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_JALR: return FMT_I;
            OPCODE_STORE:                            return FMT_S;
            OPCODE_BRANCH:                           return FMT_B;
            OPCODE_LUI, OPCODE_AUIPC:                return FMT_U;
            OPCODE_JAL:                              return FMT_J;
            default:                                 return FMT_ILLEGAL;
        endcase
    endfunction
endpackage

// File: rtl/instr_pack.sv
// instr_pack: packs instruction fields into an RV32I word for a given format
module instr_pack
    import riscv_pkg::*;
(
    input  logic [6:0]  opcode,
    input  instr_fmt_t  fmt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        range_err
);
    // an immediate sign-fits N bits when bits [31:N-1] are all equal
    logic fit12, fit13, fit21;
    assign fit12 = &imm[31:11] | ~|imm[31:11];
    assign fit13 = &imm[31:12] | ~|imm[31:12];
    assign fit21 = &imm[31:20] | ~|imm[31:20];

    always_comb begin
        instr = 32'd0;
        range_err = 1'b0;
        case (fmt)
            FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                instr = {imm[11:0], rs1, funct3, rd, opcode};
                range_err = !fit12;
            end
            FMT_S: begin
                instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                range_err = !fit12;
            end
            FMT_B: begin
                instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                range_err = !fit13 || imm[0];
            end
            FMT_U: begin
                instr = {imm[31:12], rd, opcode};
                range_err = |imm[11:0];
            end
            FMT_J: begin
                instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                range_err = !fit21 || imm[0];
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: field-level requests -> addressed RV32I words over a valid/ready stream
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic [ADDR_W:0]   out_count,
    output logic              err_illegal,
    output logic              err_range
);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    instr_fmt_t        fmt;
    logic [31:0]       word;
    logic              range_err, accept, legal, load, handshake;
    logic [ADDR_W-1:0] addr, cur_addr;

    assign fmt       = opcode_to_fmt(in_opcode);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign legal     = fmt != FMT_ILLEGAL;
    assign load      = accept && legal;
    assign handshake = out_valid && out_ready;
    assign cur_addr  = restart ? BASE : addr;

    instr_pack u_pack (
        .opcode    (in_opcode),
        .fmt       (fmt),
        .rd        (in_rd),
        .rs1       (in_rs1),
        .rs2       (in_rs2),
        .funct3    (in_funct3),
        .funct7    (in_funct7),
        .imm       (in_imm),
        .instr     (word),
        .range_err (range_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_instr   <= 32'd0;
            out_addr    <= BASE;
            addr        <= BASE;
            out_count   <= '0;
            err_illegal <= 1'b0;
            err_range   <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_instr <= word;
                out_addr  <= cur_addr;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            addr <= cur_addr + ADDR_W'(load);
            // a word still pending across restart is counted afresh when it leaves
            out_count   <= restart ? (ADDR_W+1)'(handshake)
                         : (handshake && !(&out_count)) ? out_count + 1'b1 : out_count;
            err_illegal <= (err_illegal && !restart) || (accept && !legal);
            err_range   <= (err_range && !restart) || (load && range_err);
        end
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder for the RV32I core's program-load and stimulus path: the reverse of the core's opcode decoder.
- Accepts field-level instruction requests (opcode, register indices, funct fields, immediate).
- Packs each request into a 32-bit RV32I word in the format implied by the opcode.
- Emits the word with a sequential instruction-memory word address over a valid/ready stream.
- Sits between the test or loader front end and the instruction-memory write port. Flags illegal opcodes and out-of-range immediates.

## Interface
Parameters:
- ADDR_W, 10, word-address width of instruction memory
- BASE_ADDR, 0, word address assigned after reset or restart

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- restart  in  1  pulse: reset address counter and error flags to initial values
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_opcode  in  7  RV32I opcode (riscv_pkg OPCODE_*)
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R-type only)
- in_imm  in  32  immediate, byte-offset value; U-type uses in_imm[31:12]
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer ready
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  word address for out_instr
- out_count  out  ADDR_W+1  words emitted since reset/restart
- err_illegal  out  1  sticky: illegal opcode seen
- err_range  out  1  sticky: immediate out of range or misaligned

## Operation
- Format by opcode:
  - R: OP
  - I: OP_IMM, LOAD, JALR
  - S: STORE
  - B: BRANCH
  - U: LUI, AUIPC
  - J: JAL
- Fields a format does not use are forced to 0.
- Standard RV32I bit placement:
  - I: imm[11:0] at [31:20]
  - S: imm[11:5] at [31:25], imm[4:0] at [11:7]
  - B: imm[12|10:5] at [31:25], imm[4:1|11] at [11:7]
  - U: imm[31:12] at [31:12]
  - J: imm[20|10:1|11|19:12] at [31:12]
- Range rules; any violation sets err_range, and the word is still emitted with truncated bits:
  - I/S: in_imm must sign-fit 12 bits.
  - B: must sign-fit 13 bits, with imm[0]=0.
  - J: must sign-fit 21 bits, with imm[0]=0.
  - U: in_imm[11:0] must be 0.
- Illegal opcode (any other value):
  - Request is accepted and dropped; err_illegal is set.
  - No output word; address and count do not advance.
- Address counter:
  - Holds the address for the next accepted legal request; increments by 1 per accepted legal request.
  - Wraps modulo 2^ADDR_W with no flag.
- out_count increments on each output handshake and saturates at 2^(ADDR_W+1)-1.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, out_instr = 0
  - out_addr = BASE_ADDR, internal address = BASE_ADDR
  - out_count = 0, err_illegal = 0, err_range = 0
- Single output register stage; latency 1 cycle from input handshake to out_valid.
- in_ready = !out_valid || out_ready, giving full throughput of one word per cycle under continuous out_ready.
- Output stability: while out_valid && !out_ready, out_instr and out_addr hold; out_valid never drops without a handshake (except on rst).
- restart:
  - Takes effect on the clock edge where it is sampled.
  - A request accepted in the same cycle gets BASE_ADDR, and the counter becomes BASE_ADDR+1.
  - Errors clear, but an error raised by that same request is set (set wins).
  - A pending output word is not cancelled; it keeps its old address and still counts.
- rst mid-stream: any pending word is discarded and all outputs take reset values.

## Structure
- riscv_pkg gains:
  - instr_fmt_t enum (FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILLEGAL)
  - function opcode_to_fmt
- OPCODE_* constants stay in riscv_pkg.
- One combinational sub-module, instr_pack: fields + format -> 32-bit word + range_err.
- Handshake, address counter, counters and error flags live in instr_encoder.

## Test plan
- addi x1,x0,5 (OP_IMM, rd=1, f3=0, imm=5) after reset -> out_instr 0x00500093, out_addr 0, out_valid one cycle after the input handshake.
- Back-to-back with out_ready=1:
  - Inputs: add x3,x1,x2; sw x2,8(x1); lui x5,0x12345000.
  - Expect 0x002081B3 / 0x0020A423 / 0x123452B7 at addrs 0/1/2 on consecutive cycles; out_count=3.
- beq x1,x2,imm=-4 and jal x1,imm=8:
  - Expect 0xFE208EE3 and 0x008000EF; err_range=0.
  - Then beq with imm=3 -> err_range=1 and the word is still emitted.
- out_ready=0 for 5 cycles with in_valid held:
  - out_instr/out_addr stable, in_ready=0.
  - On release, exactly one handshake per word, none lost or duplicated.
- in_opcode=0x7F -> accepted, no output, err_illegal=1, next legal word keeps the unadvanced address.
- restart asserted together with a request -> that word gets BASE_ADDR.
- Counter wraps from 2^ADDR_W-1 to 0.
- rst asserted with out_valid=1 -> out_valid=0 and all outputs at reset values immediately.
